// File: rtl/hex_display_scanner.sv
// Time-multiplexed 4-digit 7-segment hex scanner with per-slot blank band and per-frame value sampling.
// Optional leading-zero suppression is enabled by defining HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_display_scanner #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        enable,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q, tick_d;
  logic [3:0]    nibble;
  logic          digit_lit;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    shadow_d = shadow_q;
    tick_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = SCAN;
          cnt_d    = '0;
          dig_d    = '0;
          shadow_d = value;
          tick_d   = 1'b1;
        end
      end
      default: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          dig_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          dig_d = dig_q + 2'd1;
          if (dig_q == 2'd3) begin
            shadow_d = value;
            tick_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs are derived from next-state values so the registered outputs line up with cnt/dig.
  always_comb begin
    nibble = 4'(shadow_d >> {dig_d, 2'b00});
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    case (dig_d)
      2'd3:    digit_lit = |shadow_d[15:12];
      2'd2:    digit_lit = |shadow_d[15:8];
      2'd1:    digit_lit = |shadow_d[15:4];
      default: digit_lit = 1'b1;
    endcase
`else
    digit_lit = 1'b1;
`endif
    an_d  = '1;
    seg_d = '1;
    if (state_d == SCAN && cnt_d >= BLANK_END && digit_lit) begin
      an_d[dig_d] = 1'b0;
      seg_d       = decode(nibble);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dig_q    <= '0;
      shadow_q <= '0;
      seg_q    <= '1;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with CLK_DIV=8, BLANK_CYCLES=2; outputs sampled on negedge.
module tb_hex_display_scanner;

  logic        clk;
  logic        reset_n;
  logic [15:0] value;
  logic        enable;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        done     = 1'b0;

  hex_display_scanner #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .enable     (enable),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!done) begin
      n_checks++;
      if ($countones(~an_n) > 1) begin
        n_fail++;
        $display("FAIL onehot_anode t=%0t an_n=%h (at most one zero bit required)", $time, an_n);
      end
    end
  end

  task automatic chk_out(input string name, input logic [3:0] ea, input logic [6:0] es, input logic et);
    n_checks++;
    if (an_n !== ea || seg_n !== es || frame_tick !== et) begin
      n_fail++;
      $display("FAIL %s t=%0t an_n=%h seg_n=%h tick=%b expected an_n=%h seg_n=%h tick=%b",
               name, $time, an_n, seg_n, frame_tick, ea, es, et);
    end
  endtask

  // Checks 32 consecutive cycles of a frame; the first negedge must follow the frame-start edge.
  task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] lit,
                             input int chg_k);
    logic [6:0] segs [4];
    logic [3:0] one;
    logic [3:0] ea;
    logic [6:0] es;
    int slot, pos;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    one = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      slot = k / 8;
      pos  = k % 8;
      if (pos < 2 || !lit[slot]) begin
        ea = 4'hF;
        es = 7'h7F;
      end else begin
        ea = ~(one << slot);
        es = segs[slot];
      end
      chk_out(name, ea, es, k == 0);
      if (k == chg_k) value = 16'hABCD;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    enable  = 1'b0;
    value   = 16'h0000;
    #12;
    chk_out("reset_values", 4'hF, 7'h7F, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_out("idle_after_reset", 4'hF, 7'h7F, 1'b0);
    end
  endtask

  task automatic test_scan;
    value  = 16'h1234;
    enable = 1'b1;
    check_frame("frame_1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 12);
    check_frame("frame_abcd", 7'h21, 7'h46, 7'h03, 7'h08, 4'hF, -1);
  endtask

  task automatic test_enable_drop;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k == 0)  chk_out("drop_frame_start", 4'hF, 7'h7F, 1'b1);
      if (k == 18) chk_out("drop_digit2_lit", 4'hB, 7'h03, 1'b0);
    end
    enable = 1'b0;
    @(negedge clk);
    chk_out("drop_dark", 4'hF, 7'h7F, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    chk_out("restart_tick", 4'hF, 7'h7F, 1'b1);
    @(negedge clk);
    chk_out("restart_blank", 4'hF, 7'h7F, 1'b0);
    @(negedge clk);
    chk_out("restart_digit0", 4'hE, 7'h21, 1'b0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    chk_out("pre_reset_lit", 4'hE, 7'h21, 1'b0);
    #2;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    chk_out("async_reset_dark", 4'hF, 7'h7F, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_out("idle_until_enable", 4'hF, 7'h7F, 1'b0);
    end
  endtask

  task automatic test_leading_zero;
    value  = 16'h0005;
    enable = 1'b1;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    check_frame("zero_blank", 7'h12, 7'h40, 7'h40, 7'h40, 4'b0001, -1);
`else
    check_frame("zero_shown", 7'h12, 7'h40, 7'h40, 7'h40, 4'b1111, -1);
`endif
  endtask

  // enable dropped exactly on the frame-wrap edge must not produce a tick.
  task automatic test_wrap_disable;
    enable = 1'b0;
    @(negedge clk);
    chk_out("wrap_disable_no_tick", 4'hF, 7'h7F, 1'b0);
    @(negedge clk);
    chk_out("wrap_disable_idle", 4'hF, 7'h7F, 1'b0);
  endtask

  initial begin
    test_reset;
    test_scan;
    test_enable_drop;
    test_async_reset;
    test_leading_zero;
    test_wrap_disable;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t bench did not complete", $time);
    $fatal(1, "timeout");
  end

endmodule
